// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the FIR coefficient bank.
// Holds the load FSM state encoding, config mode values and reset coefficient.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_COEF,
      LOAD_ADDR,
      PENDING
   } state_t;

   localparam logic CFG_MODE_STREAM = 1'b0;
   localparam logic CFG_MODE_ADDR   = 1'b1;

   localparam logic [7:0] RESET_COEF = 8'h40;

endpackage

// File: rtl/fir_coef_regfile.sv
// fir_coef_regfile: shadow and active coefficient arrays.
// Shadow takes writes; active is only replaced by a bulk commit.
module fir_coef_regfile #(
   parameter int NTAPS = 16,
   parameter int COEF_W = 8,
   parameter int TN_W = $clog2(NTAPS),
   parameter logic [COEF_W-1:0] RESET_COEF = 8'h40
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en_i,
   input  logic [TN_W-1:0]         wr_addr_i,
   input  logic [COEF_W-1:0]       wr_data_i,
   input  logic                    restore_i,
   input  logic                    commit_i,
   input  logic                    commit_clr_i,
   input  logic [TN_W-1:0]         commit_tn_i,
   output logic [NTAPS*COEF_W-1:0] coef_flat_o
);
   import fir_pkg::*;

   localparam logic [TN_W:0] NSLOT = (TN_W+1)'(NTAPS);

   logic [COEF_W-1:0] shadow_q [NTAPS];
   logic [COEF_W-1:0] active_q [NTAPS];
   logic [COEF_W-1:0] commit_d [NTAPS];
   logic              wr_ok;

   assign wr_ok = wr_en_i && ({1'b0, wr_addr_i} < NSLOT);

   // Commit image: stream loads clear every slot above the tap count
   always_comb begin
      for (int i = 0; i < NTAPS; i++) begin
         if (commit_clr_i && (i > int'(commit_tn_i)))
            commit_d[i] = '0;
         else
            commit_d[i] = shadow_q[i];
      end
   end

   // Bank storage: restore beats commit beats write; shadow tracks commits
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NTAPS; i++) begin
            shadow_q[i] <= RESET_COEF;
            active_q[i] <= RESET_COEF;
         end
      end else if (restore_i) begin
         for (int i = 0; i < NTAPS; i++)
            shadow_q[i] <= active_q[i];
      end else if (commit_i) begin
         for (int i = 0; i < NTAPS; i++) begin
            active_q[i] <= commit_d[i];
            shadow_q[i] <= commit_d[i];
         end
      end else if (wr_ok) begin
         shadow_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Flatten the active bank for the MAC array
   always_comb begin
      coef_flat_o = '0;
      for (int i = 0; i < NTAPS; i++)
         coef_flat_o[i*COEF_W +: COEF_W] = active_q[i];
   end

endmodule

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: coefficient/tap-count store with stream and addressed loads.
// Loads fill a shadow bank that is committed atomically on a sample strobe.
module fir_coef_bank #(
   parameter int NTAPS = 16,
   parameter int COEF_W = 8,
   parameter int TN_W = $clog2(NTAPS),
   parameter logic [COEF_W-1:0] RESET_COEF = fir_pkg::RESET_COEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic                    cfg_mode,
   input  logic [TN_W-1:0]         cfg_addr,
   input  logic [COEF_W-1:0]       cfg_data,
   input  logic                    cfg_last,
   input  logic                    cfg_abort,
   input  logic                    sample_strobe,
   output logic [NTAPS*COEF_W-1:0] coef_flat,
   output logic [TN_W-1:0]         tap_num,
   output logic                    busy,
   output logic                    commit_done,
   output logic                    err
);
   import fir_pkg::*;

   localparam logic [TN_W-1:0] TN_MAX  = TN_W'(NTAPS - 1);
   localparam logic [TN_W:0]   TN_MAXW = (TN_W+1)'(NTAPS - 1);

   state_t          state_q;
   logic [TN_W-1:0] tcnt_q;
   logic [TN_W-1:0] idx_q;
   logic [TN_W-1:0] tap_num_q;
   logic            mode_q;
   logic            commit_done_q;
   logic            err_q;

   logic            beat;
   logic            abort_act;
   logic            strm_err;
   logic            wr_en;
   logic            restore;
   logic            commit;
   logic [TN_W-1:0] wr_addr;
   logic [TN_W-1:0] hdr_sat;

   assign cfg_ready   = (state_q != PENDING);
   assign busy        = (state_q != IDLE);
   assign tap_num     = tap_num_q;
   assign commit_done = commit_done_q;
   assign err         = err_q;

   assign beat      = cfg_valid && cfg_ready;
   assign abort_act = cfg_abort && (state_q != IDLE);

   // Header tap counts beyond the last slot clamp to the last slot
   assign hdr_sat = ({1'b0, cfg_data[TN_W-1:0]} > TN_MAXW)
                  ? TN_MAX : cfg_data[TN_W-1:0];

   // Stream length error: last flag must coincide with the final index
   assign strm_err = beat && !abort_act
                  && (state_q == LOAD_COEF)
                  && (cfg_last != (idx_q == tcnt_q));

   // Shadow write port control
   always_comb begin
      wr_en = 1'b0;
      if (beat && !abort_act && !strm_err) begin
         unique case (1'b1)
            (state_q == IDLE):      wr_en = (cfg_mode == CFG_MODE_ADDR);
            (state_q == LOAD_COEF): wr_en = 1'b1;
            (state_q == LOAD_ADDR): wr_en = 1'b1;
            default:                wr_en = 1'b0;
         endcase
      end
   end

   assign wr_addr = (state_q == LOAD_COEF) ? idx_q : cfg_addr;
   assign restore = abort_act || strm_err;
   assign commit  = (state_q == PENDING) && sample_strobe && !abort_act;

   // Load/commit FSM with registered tap count and pulse outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         tcnt_q        <= TN_MAX;
         idx_q         <= '0;
         tap_num_q     <= TN_MAX;
         mode_q        <= CFG_MODE_STREAM;
         commit_done_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         commit_done_q <= 1'b0;
         err_q         <= 1'b0;
         if (abort_act) begin
            state_q <= IDLE;
            tcnt_q  <= tap_num_q;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (beat) begin
                     if (cfg_mode == CFG_MODE_ADDR) begin
                        mode_q  <= CFG_MODE_ADDR;
                        state_q <= cfg_last ? PENDING : LOAD_ADDR;
                     end else if (cfg_last) begin
                        err_q <= 1'b1;
                     end else begin
                        mode_q  <= CFG_MODE_STREAM;
                        tcnt_q  <= hdr_sat;
                        idx_q   <= '0;
                        state_q <= LOAD_COEF;
                     end
                  end
               end
               LOAD_COEF: begin
                  if (strm_err) begin
                     err_q   <= 1'b1;
                     tcnt_q  <= tap_num_q;
                     state_q <= IDLE;
                  end else if (beat) begin
                     if (cfg_last)
                        state_q <= PENDING;
                     else
                        idx_q <= idx_q + 1'b1;
                  end
               end
               LOAD_ADDR: begin
                  if (beat && cfg_last)
                     state_q <= PENDING;
               end
               PENDING: begin
                  if (commit) begin
                     tap_num_q     <= tcnt_q;
                     commit_done_q <= 1'b1;
                     state_q       <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   fir_coef_regfile #(
      .NTAPS      (NTAPS),
      .COEF_W     (COEF_W),
      .TN_W       (TN_W),
      .RESET_COEF (RESET_COEF)
   ) u_regfile (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en_i      (wr_en),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (cfg_data),
      .restore_i    (restore),
      .commit_i     (commit),
      .commit_clr_i (mode_q == CFG_MODE_STREAM),
      .commit_tn_i  (tcnt_q),
      .coef_flat_o  (coef_flat)
   );

endmodule

// File: tb/tb_fir_coef_bank.sv
// tb_fir_coef_bank: scenario tasks plus randomized loads against a bank model.
// The model tracks only the committed coefficient set and tap count.
module tb_fir_coef_bank;

   localparam int NT = 16;
   localparam int CW = 8;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_valid;
   logic          cfg_ready;
   logic          cfg_mode;
   logic [TW-1:0] cfg_addr;
   logic [CW-1:0] cfg_data;
   logic          cfg_last;
   logic          cfg_abort;
   logic          sample_strobe;
   logic [NT*CW-1:0] coef_flat;
   logic [TW-1:0] tap_num;
   logic          busy;
   logic          commit_done;
   logic          err;

   int checks = 0;
   int errors = 0;

   logic [CW-1:0] exp_coef [NT];
   logic [TW-1:0] exp_tn;

   always #5 clk = ~clk;

   fir_coef_bank #(
      .NTAPS  (NT),
      .COEF_W (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_mode      (cfg_mode),
      .cfg_addr      (cfg_addr),
      .cfg_data      (cfg_data),
      .cfg_last      (cfg_last),
      .cfg_abort     (cfg_abort),
      .sample_strobe (sample_strobe),
      .coef_flat     (coef_flat),
      .tap_num       (tap_num),
      .busy          (busy),
      .commit_done   (commit_done),
      .err           (err)
   );

   function automatic logic [NT*CW-1:0] exp_flat();
      logic [NT*CW-1:0] f;
      f = '0;
      for (int i = 0; i < NT; i++)
         f[i*CW +: CW] = exp_coef[i];
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NT; i++)
         exp_coef[i] = 8'h40;
      exp_tn = 4'd15;
   endtask

   task automatic beat(input logic m, input logic [TW-1:0] a,
                       input logic [CW-1:0] d, input logic l,
                       input logic ab, input logic st);
      cfg_valid = 1'b1;
      cfg_mode = m;
      cfg_addr = a;
      cfg_data = d;
      cfg_last = l;
      cfg_abort = ab;
      sample_strobe = st;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      cfg_last = 1'b0;
      cfg_abort = 1'b0;
      sample_strobe = 1'b0;
   endtask

   task automatic strobe();
      sample_strobe = 1'b1;
      @(posedge clk);
      #1;
      sample_strobe = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cfg_valid = 1'b0;
      cfg_mode = 1'b0;
      cfg_addr = '0;
      cfg_data = '0;
      cfg_last = 1'b0;
      cfg_abort = 1'b0;
      sample_strobe = 1'b0;
      cycles(2);
      model_reset();
      checks++;
      if (coef_flat !== exp_flat()) begin
         errors++;
         $display("FAIL reset_coef: got %h want %h", coef_flat, exp_flat());
      end
      checks++;
      if (tap_num !== exp_tn) begin
         errors++;
         $display("FAIL reset_tap_num: got %0d want %0d", tap_num, exp_tn);
      end
      checks++;
      if ({busy, cfg_ready, commit_done, err} !== 4'b0100) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0100",
                  {busy, cfg_ready, commit_done, err});
      end
      rst_n = 1'b1;
      cycles(1);
   endtask

   task automatic test_stream();
      logic [CW-1:0] v [4];
      v[0] = 8'h10; v[1] = 8'h20; v[2] = 8'h30; v[3] = 8'h40;
      beat(1'b0, '0, 8'h03, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         beat(1'b0, '0, v[i], i == 3, 1'b0, 1'b0);
      checks++;
      if ({busy, cfg_ready} !== 2'b10 || coef_flat !== exp_flat()) begin
         errors++;
         $display("FAIL stream_pending: busy %b ready %b flat %h want 1 0 %h",
                  busy, cfg_ready, coef_flat, exp_flat());
      end
      strobe();
      for (int i = 0; i < NT; i++)
         exp_coef[i] = (i < 4) ? v[i] : 8'h00;
      exp_tn = 4'd3;
      checks++;
      if (coef_flat !== exp_flat()) begin
         errors++;
         $display("FAIL stream_commit: got %h want %h", coef_flat, exp_flat());
      end
      checks++;
      if (tap_num !== exp_tn || commit_done !== 1'b1) begin
         errors++;
         $display("FAIL stream_tn_done: tn %0d done %b want %0d 1",
                  tap_num, commit_done, exp_tn);
      end
      cycles(1);
      checks++;
      if (commit_done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stream_done_once: done %b busy %b want 0 0",
                  commit_done, busy);
      end
   endtask

   task automatic test_addressed();
      int bad;
      bad = 0;
      beat(1'b1, 4'd5, 8'hF0, 1'b0, 1'b0, 1'b0);
      beat(1'b1, 4'd15, 8'h7F, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 20; c++) begin
         if (coef_flat !== exp_flat() || cfg_ready !== 1'b0 || busy !== 1'b1)
            bad++;
         cycles(1);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL addr_hold: %0d bad cycles, want 0", bad);
      end
      strobe();
      exp_coef[5] = 8'hF0;
      exp_coef[15] = 8'h7F;
      checks++;
      if (coef_flat !== exp_flat()) begin
         errors++;
         $display("FAIL addr_commit: got %h want %h", coef_flat, exp_flat());
      end
      checks++;
      if (tap_num !== exp_tn || commit_done !== 1'b1) begin
         errors++;
         $display("FAIL addr_tn_done: tn %0d done %b want %0d 1",
                  tap_num, commit_done, exp_tn);
      end
      cycles(1);
   endtask

   task automatic test_stream_err();
      beat(1'b0, '0, 8'h02, 1'b0, 1'b0, 1'b0);
      beat(1'b0, '0, 8'h11, 1'b0, 1'b0, 1'b0);
      beat(1'b0, '0, 8'h22, 1'b1, 1'b0, 1'b0);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL serr_pulse: err %b busy %b want 1 0", err, busy);
      end
      cycles(1);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL serr_once: err %b want 0", err);
      end
      strobe();
      checks++;
      if (coef_flat !== exp_flat() || commit_done !== 1'b0
          || tap_num !== exp_tn) begin
         errors++;
         $display("FAIL serr_nocommit: flat %h done %b tn %0d want %h 0 %0d",
                  coef_flat, commit_done, tap_num, exp_flat(), exp_tn);
      end
   endtask

   task automatic test_abort();
      logic [CW-1:0] v;
      v = 8'($urandom);
      beat(1'b0, '0, 8'h05, 1'b0, 1'b0, 1'b0);
      beat(1'b0, '0, 8'($urandom), 1'b0, 1'b0, 1'b0);
      beat(1'b0, '0, 8'($urandom), 1'b0, 1'b0, 1'b0);
      beat(1'b0, '0, 8'($urandom), 1'b0, 1'b1, 1'b0);
      checks++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: busy %b err %b want 0 0", busy, err);
      end
      beat(1'b1, 4'd0, v, 1'b1, 1'b0, 1'b0);
      strobe();
      exp_coef[0] = v;
      checks++;
      if (coef_flat !== exp_flat() || tap_num !== exp_tn) begin
         errors++;
         $display("FAIL abort_clean: flat %h tn %0d want %h %0d",
                  coef_flat, tap_num, exp_flat(), exp_tn);
      end
      cycles(1);
   endtask

   task automatic test_same_cycle();
      logic [CW-1:0] v;
      v = 8'($urandom);
      beat(1'b1, 4'd7, v, 1'b1, 1'b0, 1'b1);
      checks++;
      if (busy !== 1'b1 || commit_done !== 1'b0 || coef_flat !== exp_flat()) begin
         errors++;
         $display("FAIL same_nocommit: busy %b done %b flat %h want 1 0 %h",
                  busy, commit_done, coef_flat, exp_flat());
      end
      cycles(2);
      checks++;
      if (commit_done !== 1'b0 || coef_flat !== exp_flat()) begin
         errors++;
         $display("FAIL same_wait: done %b flat %h want 0 %h",
                  commit_done, coef_flat, exp_flat());
      end
      strobe();
      exp_coef[7] = v;
      checks++;
      if (commit_done !== 1'b1 || coef_flat !== exp_flat()) begin
         errors++;
         $display("FAIL same_next: done %b flat %h want 1 %h",
                  commit_done, coef_flat, exp_flat());
      end
      cycles(1);
   endtask

   task automatic test_reset_pending();
      beat(1'b1, 4'd3, 8'($urandom), 1'b1, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rstp_pending: busy %b want 1", busy);
      end
      rst_n = 1'b0;
      cycles(1);
      rst_n = 1'b1;
      model_reset();
      checks++;
      if (coef_flat !== exp_flat() || tap_num !== exp_tn) begin
         errors++;
         $display("FAIL rstp_vals: flat %h tn %0d want %h %0d",
                  coef_flat, tap_num, exp_flat(), exp_tn);
      end
      checks++;
      if ({busy, cfg_ready, commit_done, err} !== 4'b0100) begin
         errors++;
         $display("FAIL rstp_flags: got %b want 0100",
                  {busy, cfg_ready, commit_done, err});
      end
      strobe();
      checks++;
      if (coef_flat !== exp_flat() || commit_done !== 1'b0) begin
         errors++;
         $display("FAIL rstp_nocommit: flat %h done %b want %h 0",
                  coef_flat, commit_done, exp_flat());
      end
   endtask

   task automatic test_random();
      int kind, t, n, k;
      logic [CW-1:0] vals [NT];
      logic [TW-1:0] a;
      logic [CW-1:0] d;
      for (int it = 0; it < 40; it++) begin
         kind = $urandom_range(0, 3);
         if (kind <= 1) begin
            t = $urandom_range(0, NT - 1);
            for (int i = 0; i < NT; i++)
               vals[i] = 8'($urandom);
            beat(1'b0, 4'($urandom), {4'($urandom), 4'(t)}, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i <= t; i++)
               beat(1'b0, 4'($urandom), vals[i], i == t, 1'b0, 1'b0);
            strobe();
            for (int i = 0; i < NT; i++)
               exp_coef[i] = (i <= t) ? vals[i] : 8'h00;
            exp_tn = 4'(t);
         end else if (kind == 2) begin
            t = $urandom_range(0, NT - 1);
            n = $urandom_range(0, t);
            beat(1'b0, '0, 8'(t), 1'b0, 1'b0, 1'b0);
            for (int i = 0; i <= n; i++)
               beat(1'b0, '0, 8'($urandom), (i == n) && (n < t), 1'b0, 1'b0);
            checks++;
            if (err !== 1'b1) begin
               errors++;
               $display("FAIL rnd_err it%0d: err %b want 1 (t=%0d n=%0d)",
                        it, err, t, n);
            end
            strobe();
         end else begin
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++) begin
               a = 4'($urandom);
               d = 8'($urandom);
               beat(1'b1, a, d, j == k - 1, 1'b0, 1'b0);
               exp_coef[a] = d;
            end
            strobe();
         end
         checks++;
         if (coef_flat !== exp_flat()) begin
            errors++;
            $display("FAIL rnd_flat it%0d: got %h want %h",
                     it, coef_flat, exp_flat());
         end
         checks++;
         if (tap_num !== exp_tn) begin
            errors++;
            $display("FAIL rnd_tn it%0d: got %0d want %0d", it, tap_num, exp_tn);
         end
         cycles(1);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_addressed();
      test_stream_err();
      test_abort();
      test_same_cycle();
      test_reset_pending();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
